// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } pc_seq_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences PC from EX branch resolution, drives IF/ID and
// ID/EX pipeline controls, and handles load-use stall, boot and halt.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      br_pc,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_cnt
);

    pc_seq_state_e   state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_plus;
    logic [PC_W-1:0] br_target;
    logic            redirect;
    logic            unused_br_hi;

    // Upper target bits lie outside the instruction address space.
    assign unused_br_hi = ^br_pc[31:PC_W];

    assign pc_plus   = pc + PC_W'(INSTR_BYTES);
    assign br_target = {br_pc[PC_W-1:2], 2'b00};
    assign halted    = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (pc_en)
                pc <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_plus;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        redirect    = 1'b0;
        case (state)
            BOOT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = RUN;
            end
            RUN, REDIRECT: begin
                // In REDIRECT the EX slot holds a flushed bubble, so pc_sel is stale.
                if ((state == RUN) && pc_sel) begin
                    redirect    = 1'b1;
                    pc_en       = 1'b1;
                    pc_nxt      = br_target;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nxt   = REDIRECT;
                end else if (halt_req) begin
                    id_ex_flush = 1'b1;
                    state_nxt   = HALT;
                end else if (stall) begin
                    id_ex_flush = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    state_nxt = RUN;
                end
            end
            HALT: begin
                id_ex_flush = 1'b1;
                if (resume)
                    state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_err <= 1'b0;
        else if (redirect && (br_pc[1:0] != 2'b00))
            misalign_err <= 1'b1;
    end

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect),
        .cnt   (taken_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, redirect, stall, halt, wrap, saturation, reset.
module tb_pc_sequencer;

    localparam int PC_W  = 9;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, pc_sel, halt_req, resume;
    logic [31:0]      br_pc;
    logic [PC_W-1:0]  pc;
    logic             pc_en, if_id_en, if_id_flush, id_ex_flush, halted, misalign_err;
    logic [CNT_W-1:0] taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .br_pc        (br_pc),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .halted       (halted),
        .misalign_err (misalign_err),
        .taken_cnt    (taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'h0);
        chk({tag, ".pc_en"}, 32'(pc_en), 32'h0);
        chk({tag, ".if_id_en"}, 32'(if_id_en), 32'h0);
        chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'h1);
        chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'h1);
        chk({tag, ".halted"}, 32'(halted), 32'h0);
        chk({tag, ".misalign"}, 32'(misalign_err), 32'h0);
        chk({tag, ".taken"}, 32'(taken_cnt), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_sel = 1'b0; br_pc = '0;
        halt_req = 1'b0; resume = 1'b0;
        #3;
        chk_reset_vals("rst");
        tick(); tick();
        rst_n = 1'b1;

        // Boot: BOOT cycle then a RUN cycle both at 0, then linear fetch
        #1;
        chk("boot.pc", 32'(pc), 32'h0);
        chk("boot.if_id_flush", 32'(if_id_flush), 32'h1);
        chk("boot.pc_en", 32'(pc_en), 32'h0);
        tick();
        chk("run0.pc", 32'(pc), 32'h0);
        chk("run0.if_id_flush", 32'(if_id_flush), 32'h0);
        chk("run0.pc_en", 32'(pc_en), 32'h1);
        chk("run0.if_id_en", 32'(if_id_en), 32'h1);
        tick(); chk("seq.pc4", 32'(pc), 32'h4);
        tick(); chk("seq.pc8", 32'(pc), 32'h8);
        tick(); chk("seq.pc12", 32'(pc), 32'hC);
        tick(); chk("seq.pc16", 32'(pc), 32'h10);

        // Redirect at 0x10, pc_sel held into REDIRECT cycle is ignored
        pc_sel = 1'b1; br_pc = 32'h40; #1;
        chk("br.if_id_flush", 32'(if_id_flush), 32'h1);
        chk("br.id_ex_flush", 32'(id_ex_flush), 32'h1);
        tick();
        chk("br.pc", 32'(pc), 32'h40);
        chk("br.taken", 32'(taken_cnt), 32'h1);
        chk("redir.if_id_flush", 32'(if_id_flush), 32'h0);
        tick();
        chk("redir.pc", 32'(pc), 32'h44);
        chk("redir.taken", 32'(taken_cnt), 32'h1);

        // Stall two cycles at 0x20 (first one in REDIRECT)
        br_pc = 32'h20;
        tick();
        chk("st.pc_target", 32'(pc), 32'h20);
        pc_sel = 1'b0; stall = 1'b1; #1;
        chk("st1.pc_en", 32'(pc_en), 32'h0);
        chk("st1.id_ex_flush", 32'(id_ex_flush), 32'h1);
        chk("st1.if_id_en", 32'(if_id_en), 32'h0);
        tick();
        chk("st2.pc", 32'(pc), 32'h20);
        chk("st2.id_ex_flush", 32'(id_ex_flush), 32'h1);
        chk("st2.if_id_flush", 32'(if_id_flush), 32'h0);
        tick();
        chk("st3.pc", 32'(pc), 32'h20);
        stall = 1'b0;
        tick();
        chk("st.pc24", 32'(pc), 32'h24);
        stall = 1'b1; pc_sel = 1'b1; br_pc = 32'h80; #1;
        chk("stbr.if_id_flush", 32'(if_id_flush), 32'h1);
        tick();
        chk("stbr.pc", 32'(pc), 32'h80);
        chk("stbr.taken", 32'(taken_cnt), 32'h3);
        stall = 1'b0; pc_sel = 1'b0;
        tick();
        chk("stbr.pc84", 32'(pc), 32'h84);

        // Halt: ebreak at 0x30 sits in ID while IF fetches 0x34
        pc_sel = 1'b1; br_pc = 32'h30;
        tick();
        pc_sel = 1'b0;
        tick();
        chk("h.pc34", 32'(pc), 32'h34);
        halt_req = 1'b1; #1;
        chk("h.pc_en", 32'(pc_en), 32'h0);
        chk("h.id_ex_flush", 32'(id_ex_flush), 32'h1);
        chk("h.halted_pre", 32'(halted), 32'h0);
        tick();
        chk("h.halted", 32'(halted), 32'h1);
        halt_req = 1'b0; pc_sel = 1'b1; br_pc = 32'h100; stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("h.pc_frozen", 32'(pc), 32'h34);
        chk("h.taken_frozen", 32'(taken_cnt), 32'h4);
        chk("h.still", 32'(halted), 32'h1);
        pc_sel = 1'b0; stall = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("res.halted", 32'(halted), 32'h0);
        tick();
        chk("res.pc38", 32'(pc), 32'h38);

        // Misaligned target and PC wrap; upper br_pc bits ignored
        pc_sel = 1'b1; br_pc = 32'h102;
        tick();
        pc_sel = 1'b0;
        chk("mis.pc", 32'(pc), 32'h100);
        chk("mis.err", 32'(misalign_err), 32'h1);
        tick();
        pc_sel = 1'b1; br_pc = 32'hFFFF_FFFC;
        tick();
        pc_sel = 1'b0;
        chk("wrap.pc1fc", 32'(pc), 32'h1FC);
        chk("wrap.err_sticky", 32'(misalign_err), 32'h1);
        tick();
        chk("wrap.pc0", 32'(pc), 32'h0);
        chk("wrap.taken", 32'(taken_cnt), 32'h6);

        // Saturation: 11 more redirects makes 17 total
        for (int i = 0; i < 11; i++) begin
            pc_sel = 1'b1; br_pc = 32'h40;
            tick();
            pc_sel = 1'b0;
            tick();
        end
        chk("sat.taken", 32'(taken_cnt), 32'hF);

        // Reset mid-REDIRECT
        pc_sel = 1'b1; br_pc = 32'h80;
        tick();
        pc_sel = 1'b0;
        chk("rr.pc", 32'(pc), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rr");
        tick();
        rst_n = 1'b1;
        #1;
        chk("rr.boot_flush", 32'(if_id_flush), 32'h1);
        tick();
        tick();
        chk("rr.pc4", 32'(pc), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
